// File: rtl/branch_cc_sequencer.sv
// Multi-phase instruction sequencer: holds the N/Z/P condition code,
// resolves branches and strobes the next PC at each commit edge.
module branch_cc_sequencer #(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 8,
    parameter int          PHASES   = 2,
    parameter logic [2:0]  CC_RESET = 3'b000
) (
    input  logic              clka,
    input  logic              reset_in,
    input  logic              instr_valid_in,
    output logic              ready_out,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic [2:0]        nzp_dec_in,
    input  logic              br_in,
    input  logic              jmp_in,
    input  logic              we_reg_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [PC_W-1:0]   offset_in,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              pc_load_out,
    output logic [PC_W-1:0]   pc_next_out,
    output logic              taken_out,
    output logic [2:0]        cc_out,
    output logic [3:0]        phase_out
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] LAST = 4'(PHASES - 1);

    state_t            state_q;
    logic [3:0]        phase_q;
    logic [2:0]        cc_q;
    logic [2:0]        cc_old_q;
    logic [2:0]        nzp_q;
    logic              br_q;
    logic              jmp_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   off_q;
    logic              pc_load_q;
    logic              taken_q;
    logic [PC_W-1:0]   pc_next_q;

    logic              accept;
    logic              taken_d;
    logic [PC_W-1:0]   pc_next_d;
    logic [2:0]        cc_d;

    assign ready_out = (state_q == IDLE) & ~stall_in & ~flush_in;
    assign accept    = instr_valid_in & ready_out;

    // Branches see the CC snapshot from their own accept edge.
    assign taken_d   = jmp_q | (br_q & |(nzp_q & cc_old_q));
    assign pc_next_d = taken_d ? pc_q + off_q : pc_q + 1'b1;

    always_comb begin
        cc_d    = 3'b000;
        cc_d[2] = alu_result_in[DATA_W-1];
        cc_d[1] = (alu_result_in == '0);
        cc_d[0] = ~cc_d[2] & ~cc_d[1];
    end

    always_ff @(posedge clka or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            phase_q   <= 4'd0;
            cc_q      <= CC_RESET;
            cc_old_q  <= CC_RESET;
            nzp_q     <= 3'b000;
            br_q      <= 1'b0;
            jmp_q     <= 1'b0;
            pc_q      <= '0;
            off_q     <= '0;
            pc_load_q <= 1'b0;
            taken_q   <= 1'b0;
            pc_next_q <= '0;
        end else begin
            pc_load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        nzp_q    <= nzp_dec_in;
                        br_q     <= br_in;
                        jmp_q    <= jmp_in;
                        pc_q     <= pc_in;
                        off_q    <= offset_in;
                        cc_old_q <= cc_q;
                        phase_q  <= 4'd1;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_in) begin
                        state_q <= IDLE;
                        phase_q <= 4'd0;
                    end else if (!stall_in) begin
                        if (phase_q == LAST) begin
                            pc_load_q <= 1'b1;
                            taken_q   <= taken_d;
                            pc_next_q <= pc_next_d;
                            if (we_reg_in)
                                cc_q <= cc_d;
                            state_q <= IDLE;
                            phase_q <= 4'd0;
                        end else begin
                            phase_q <= phase_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    phase_q <= 4'd0;
                end
            endcase
        end
    end

    assign pc_load_out = pc_load_q;
    assign pc_next_out = pc_next_q;
    assign taken_out   = taken_q;
    assign cc_out      = cc_q;
    assign phase_out   = phase_q;

endmodule

// File: tb/tb_branch_cc_sequencer.sv
// Directed bench: a PHASES=2 instance runs an instruction table,
// a PHASES=4 instance covers stall timing.
module tb_branch_cc_sequencer;

    logic        clka = 1'b0;
    logic        reset_in;
    logic        stall_in, flush_in;
    logic        valid2, valid4;
    logic [2:0]  nzp;
    logic        br, jmp, we;
    logic [7:0]  pc, off;
    logic [15:0] alu;

    logic        rdy2, ld2, tk2;
    logic [7:0]  nx2;
    logic [2:0]  cc2;
    logic [3:0]  ph2;
    logic        rdy4, ld4, tk4;
    logic [7:0]  nx4;
    logic [2:0]  cc4;
    logic [3:0]  ph4;

    int errors = 0;
    int checks = 0;

    always #5 clka = ~clka;

    branch_cc_sequencer #(.DATA_W(16), .PC_W(8), .PHASES(2),
                          .CC_RESET(3'b000)) dut2 (
        .clka(clka), .reset_in(reset_in),
        .instr_valid_in(valid2), .ready_out(rdy2),
        .stall_in(stall_in), .flush_in(flush_in),
        .nzp_dec_in(nzp), .br_in(br), .jmp_in(jmp),
        .we_reg_in(we), .pc_in(pc), .offset_in(off),
        .alu_result_in(alu), .pc_load_out(ld2),
        .pc_next_out(nx2), .taken_out(tk2),
        .cc_out(cc2), .phase_out(ph2)
    );

    branch_cc_sequencer #(.DATA_W(16), .PC_W(8), .PHASES(4),
                          .CC_RESET(3'b000)) dut4 (
        .clka(clka), .reset_in(reset_in),
        .instr_valid_in(valid4), .ready_out(rdy4),
        .stall_in(stall_in), .flush_in(flush_in),
        .nzp_dec_in(nzp), .br_in(br), .jmp_in(jmp),
        .we_reg_in(we), .pc_in(pc), .offset_in(off),
        .alu_result_in(alu), .pc_load_out(ld4),
        .pc_next_out(nx4), .taken_out(tk4),
        .cc_out(cc4), .phase_out(ph4)
    );

    typedef struct {
        logic [2:0]  nzp;
        logic        br;
        logic        jmp;
        logic        we;
        logic [7:0]  pc;
        logic [7:0]  off;
        logic [15:0] alu;
        logic        tk;
        logic [7:0]  nx;
        logic [2:0]  cc;
    } vec_t;

    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int first;
        int pulses;
        int t0;

        v[0] = '{3'b000, 0, 0, 1, 8'h10, 8'h00, 16'h0000, 0, 8'h11, 3'b010};
        v[1] = '{3'b010, 1, 0, 0, 8'h20, 8'hFC, 16'h1234, 1, 8'h1C, 3'b010};
        v[2] = '{3'b000, 0, 0, 1, 8'h30, 8'h00, 16'h0005, 0, 8'h31, 3'b001};
        v[3] = '{3'b100, 1, 0, 1, 8'h40, 8'h08, 16'h8000, 0, 8'h41, 3'b100};
        v[4] = '{3'b100, 1, 0, 0, 8'h50, 8'h10, 16'h0000, 1, 8'h60, 3'b100};
        v[5] = '{3'b011, 1, 0, 0, 8'h60, 8'h10, 16'h0000, 0, 8'h61, 3'b100};
        v[6] = '{3'b000, 1, 1, 0, 8'hF0, 8'h20, 16'h0000, 1, 8'h10, 3'b100};
        v[7] = '{3'b000, 0, 0, 1, 8'hFF, 8'h00, 16'h7FFF, 0, 8'h00, 3'b001};
        v[8] = '{3'b001, 1, 0, 0, 8'h05, 8'hFB, 16'h0000, 1, 8'h00, 3'b001};
        v[9] = '{3'b111, 0, 0, 1, 8'h80, 8'h00, 16'hFFFF, 0, 8'h81, 3'b100};

        reset_in = 1'b1;
        stall_in = 1'b0; flush_in = 1'b0;
        valid2 = 1'b0; valid4 = 1'b0;
        nzp = 3'b000; br = 1'b0; jmp = 1'b0; we = 1'b0;
        pc = 8'h00; off = 8'h00; alu = 16'h0000;
        repeat (2) @(posedge clka);
        #1;
        chk("rst_phase", 32'(ph2), 32'd0);
        chk("rst_cc", 32'(cc2), 32'd0);
        chk("rst_load", 32'(ld2), 32'd0);
        chk("rst_next", 32'(nx2), 32'd0);
        chk("rst_taken", 32'(tk2), 32'd0);
        @(negedge clka);
        reset_in = 1'b0;

        // Table: back-to-back instructions, one per two cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clka);
            chk($sformatf("v%0d_ready", i), 32'(rdy2), 32'd1);
            nzp = v[i].nzp; br = v[i].br; jmp = v[i].jmp;
            we = v[i].we; pc = v[i].pc; off = v[i].off;
            alu = v[i].alu;
            valid2 = 1'b1;
            @(posedge clka); #1;
            chk($sformatf("v%0d_phase1", i), 32'(ph2), 32'd1);
            chk($sformatf("v%0d_noload", i), 32'(ld2), 32'd0);
            @(negedge clka);
            valid2 = 1'b0;
            @(posedge clka); #1;
            chk($sformatf("v%0d_load", i), 32'(ld2), 32'd1);
            chk($sformatf("v%0d_taken", i), 32'(tk2), 32'(v[i].tk));
            chk($sformatf("v%0d_next", i), 32'(nx2), 32'(v[i].nx));
            chk($sformatf("v%0d_cc", i), 32'(cc2), 32'(v[i].cc));
            chk($sformatf("v%0d_phase0", i), 32'(ph2), 32'd0);
        end
        @(posedge clka); #1;
        chk("pulse_drop", 32'(ld2), 32'd0);
        chk("hold_next", 32'(nx2), 32'h81);

        // Stall on PHASES=4: phase holds at 2 for 3 cycles
        @(negedge clka);
        nzp = 3'b000; br = 1'b0; jmp = 1'b1; we = 1'b0;
        pc = 8'h40; off = 8'h05; alu = 16'h0000;
        valid4 = 1'b1;
        @(posedge clka); #1;
        chk("s_phase1", 32'(ph4), 32'd1);
        @(negedge clka);
        valid4 = 1'b0;
        @(posedge clka); #1;
        chk("s_phase2", 32'(ph4), 32'd2);
        @(negedge clka);
        stall_in = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        chk("s_hold", 32'(ph4), 32'd2);
        chk("s_ready", 32'(rdy2), 32'd0);
        @(negedge clka);
        stall_in = 1'b0;
        first = -1; pulses = 0;
        for (int c = 5; c < 12; c++) begin
            @(posedge clka); #1;
            if (ld4) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        chk("s_latency", 32'(first), 32'd6);
        chk("s_pulses", 32'(pulses), 32'd1);
        chk("s_next", 32'(nx4), 32'h45);
        chk("s_taken", 32'(tk4), 32'd1);

        // Flush at phase 1 with a CC write pending
        @(negedge clka);
        nzp = 3'b000; br = 1'b0; jmp = 1'b0; we = 1'b1;
        pc = 8'h70; off = 8'h00; alu = 16'h0000;
        valid2 = 1'b1;
        @(posedge clka); #1;
        chk("f_phase1", 32'(ph2), 32'd1);
        @(negedge clka);
        valid2 = 1'b0;
        flush_in = 1'b1;
        @(posedge clka); #1;
        chk("f_noload", 32'(ld2), 32'd0);
        chk("f_cc", 32'(cc2), 32'b100);
        chk("f_phase0", 32'(ph2), 32'd0);
        chk("f_nx_hold", 32'(nx2), 32'h81);
        // Flush in IDLE blocks accept
        @(negedge clka);
        valid2 = 1'b1;
        chk("f_idle_rdy", 32'(rdy2), 32'd0);
        @(posedge clka); #1;
        chk("f_blocked", 32'(ph2), 32'd0);
        @(negedge clka);
        valid2 = 1'b0;
        flush_in = 1'b0;
        #1;
        chk("f_ready", 32'(rdy2), 32'd1);

        // Async reset between edges during WAIT
        @(negedge clka);
        we = 1'b0; pc = 8'h33;
        valid2 = 1'b1;
        @(posedge clka); #1;
        chk("r_phase1", 32'(ph2), 32'd1);
        @(negedge clka);
        valid2 = 1'b0;
        t0 = 0;
        #2 reset_in = 1'b1;
        #1;
        chk("r_phase", 32'(ph2), 32'd0);
        chk("r_cc", 32'(cc2), 32'd0);
        chk("r_next", 32'(nx2), 32'd0);
        chk("r_taken", 32'(tk2), 32'd0);
        chk("r_load", 32'(ld2), 32'd0);
        @(posedge clka); #1;
        chk("r_noload", 32'(ld2), 32'(t0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
